// File: rtl/unified_mem_arbiter.sv
// Shares one single-port synchronous memory between the fetch and data paths.
// Optional `ARB_ROUND_ROBIN_EN` selects round-robin arbitration instead of data-first fixed priority.
module unified_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              own_data_q, own_data_d;
  logic              op_we_q, op_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              pick_data;

`ifdef ARB_ROUND_ROBIN_EN
  // Set when the data port should win the next contested arbitration.
  logic rr_data_q, rr_data_d;
  assign pick_data = d_req && (!i_req || rr_data_q);
`else
  assign pick_data = d_req;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    own_data_d = own_data_q;
    op_we_d    = op_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    rr_data_d  = rr_data_q;
`endif
    i_gnt      = 1'b0;
    d_gnt      = 1'b0;
    i_valid    = 1'b0;
    d_valid    = 1'b0;
    m_en       = 1'b0;
    m_we       = 1'b0;
    busy       = 1'b0;
    m_addr     = m_addr_q;
    m_wdata    = m_wdata_q;
    i_rdata    = i_rdata_q;
    d_rdata    = d_rdata_q;

    case (state_q)
      S_IDLE: begin
        // Grants are suppressed while reset is asserted.
        if (RST && (i_req || d_req)) begin
          m_en = 1'b1;
          if (pick_data) begin
            d_gnt   = 1'b1;
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
          end else begin
            i_gnt   = 1'b1;
            m_addr  = i_addr;
          end
          m_addr_d   = m_addr;
          m_wdata_d  = m_wdata;
          own_data_d = pick_data;
          op_we_d    = pick_data && d_we;
          cnt_d      = CNT_INIT;
          state_d    = S_WAIT;
`ifdef ARB_ROUND_ROBIN_EN
          if (i_req && d_req) begin
            rr_data_d = !pick_data;
          end
`endif
        end
      end

      S_WAIT: begin
        busy = 1'b1;
        if (cnt_q == 2'd0) begin
          state_d = S_IDLE;
          if (RST) begin
            if (own_data_q) begin
              d_valid = 1'b1;
              if (!op_we_q) begin
                d_rdata   = m_rdata;
                d_rdata_d = m_rdata;
              end
            end else begin
              i_valid   = 1'b1;
              i_rdata   = m_rdata;
              i_rdata_d = m_rdata;
            end
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= 2'd0;
      own_data_q <= 1'b0;
      op_we_q    <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_data_q  <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      own_data_q <= own_data_d;
      op_we_q    <= op_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_data_q  <= rr_data_d;
`endif
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter at MEM_LAT=2 with a small latency-matched memory model.
module tb_unified_mem_arbiter;

  localparam int LAT = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_gnt, i_valid, d_gnt, d_valid, m_en, m_we, busy;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;

  logic [31:0] mem [16];
  logic [31:0] pipe0, pipe1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
    .CLK(CLK), .RST(RST),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .busy(busy)
  );

  // Memory: data captured on the issue edge, then one extra stage for LAT=2.
  always @(posedge CLK) begin
    if (!RST) begin
      mem[1] <= 32'h2002_0005;
    end else if (m_en && m_we) begin
      mem[m_addr[5:2]] <= m_wdata;
    end
    if (m_en) pipe0 <= mem[m_addr[5:2]];
    pipe1 <= pipe0;
  end
  assign m_rdata = pipe1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int n;
    logic [1:0] exp_g;
    RST = 1'b0; i_req = 1'b1; i_addr = 32'h4;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

    // Reset with a pending fetch: nothing granted, outputs cleared.
    @(negedge CLK);
    check("rst_i_gnt", 32'(i_gnt), 0);
    check("rst_m_en", 32'(m_en), 0);
    check("rst_m_we", 32'(m_we), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_valids", 32'({i_valid, d_valid}), 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_m_wdata", m_wdata, 0);
    check("rst_rdatas", i_rdata | d_rdata, 0);

    // Single fetch, granted in the first cycle out of reset.
    next(); RST = 1'b1;
    @(negedge CLK);
    check("f_i_gnt", 32'(i_gnt), 1);
    check("f_d_gnt", 32'(d_gnt), 0);
    check("f_m_en", 32'(m_en), 1);
    check("f_m_we", 32'(m_we), 0);
    check("f_m_addr", m_addr, 32'h4);
    next(); i_req = 1'b0;
    @(negedge CLK);
    check("f_busy1", 32'(busy), 1);
    check("f_m_en1", 32'(m_en), 0);
    check("f_valid1", 32'(i_valid), 0);
    next();
    @(negedge CLK);
    check("f_busy2", 32'(busy), 1);
    check("f_valid2", 32'(i_valid), 1);
    check("f_rdata2", i_rdata, 32'h2002_0005);
    next();
    @(negedge CLK);
    check("f_valid3", 32'(i_valid), 0);
    check("f_busy3", 32'(busy), 0);
    check("f_rdata_hold", i_rdata, 32'h2002_0005);

    // Write 0x10 then read it back.
    next(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
    @(negedge CLK);
    check("w_d_gnt", 32'(d_gnt), 1);
    check("w_m_we", 32'(m_we), 1);
    check("w_m_addr", m_addr, 32'h10);
    check("w_m_wdata", m_wdata, 32'hDEAD_BEEF);
    next(); d_req = 1'b0; d_we = 1'b0;
    @(negedge CLK);
    check("w_valid1", 32'(d_valid), 0);
    next();
    @(negedge CLK);
    check("w_valid2", 32'(d_valid), 1);
    check("w_rdata_keep", d_rdata, 0);
    check("w_i_valid", 32'(i_valid), 0);
    next(); d_req = 1'b1;
    @(negedge CLK);
    check("r_d_gnt", 32'(d_gnt), 1);
    check("r_m_we", 32'(m_we), 0);
    next(); d_req = 1'b0;
    @(negedge CLK);
    next();
    @(negedge CLK);
    check("r_valid", 32'(d_valid), 1);
    check("r_rdata", d_rdata, 32'hDEAD_BEEF);
    check("r_i_rdata_keep", i_rdata, 32'h2002_0005);

    // Contention, plus a data request toggled during WAIT.
    next(); i_req = 1'b1; i_addr = 32'h4; d_req = 1'b1; d_addr = 32'h10;
    @(negedge CLK);
    check("c_d_gnt", 32'(d_gnt), 1);
    check("c_i_gnt", 32'(i_gnt), 0);
    check("c_m_addr", m_addr, 32'h10);
    next(); d_req = 1'b1; d_we = 1'b1; d_wdata = 32'h0000_1234;
    @(negedge CLK);
    check("c_wait_gnts", 32'({i_gnt, d_gnt}), 0);
    check("c_wait_m_en", 32'(m_en), 0);
    check("c_wait_busy", 32'(busy), 1);
    next(); d_req = 1'b0; d_we = 1'b0;
    @(negedge CLK);
    check("c_d_valid", 32'(d_valid), 1);
    check("c_i_valid", 32'(i_valid), 0);
    check("c_d_rdata", d_rdata, 32'hDEAD_BEEF);
    next();
    @(negedge CLK);
    check("c_i_gnt_late", 32'(i_gnt), 1);
    check("c_i_m_addr", m_addr, 32'h4);
    next(); i_req = 1'b0;
    @(negedge CLK);
    next();
    @(negedge CLK);
    check("c_i_valid_late", 32'(i_valid), 1);
    check("c_d_valid_late", 32'(d_valid), 0);

    // Reset in the would-be valid cycle aborts the fetch.
    next(); i_req = 1'b1;
    @(negedge CLK);
    check("ra_i_gnt", 32'(i_gnt), 1);
    next(); i_req = 1'b0;
    @(negedge CLK);
    next(); RST = 1'b0;
    @(negedge CLK);
    check("ra_valid_in_rst", 32'({i_valid, d_valid}), 0);
    next(); RST = 1'b1; i_req = 1'b1;
    @(negedge CLK);
    check("ra_busy", 32'(busy), 0);
    check("ra_valids", 32'({i_valid, d_valid}), 0);
    check("ra_rdatas", i_rdata | d_rdata, 0);
    check("ra_regrant", 32'(i_gnt), 1);
    next(); i_req = 1'b0;
    @(negedge CLK);
    check("ra_busy2", 32'(busy), 1);
    next();
    @(negedge CLK);
    check("ra_valid", 32'(i_valid), 1);
    check("ra_rdata", i_rdata, 32'h2002_0005);

    // Continuous contention for four accesses.
    next(); i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    @(negedge CLK);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!(i_gnt || d_gnt) && n < 6) begin
        @(negedge CLK);
        n++;
      end
`ifdef ARB_ROUND_ROBIN_EN
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      check($sformatf("cc_gnt%0d", k), 32'({i_gnt, d_gnt}), 32'(exp_g));
      check($sformatf("cc_gap%0d", k), 32'(n), (k == 0) ? 0 : 2);
      @(negedge CLK);
    end
    next(); i_req = 1'b0; d_req = 1'b0;
    repeat (4) @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
